mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one combinational n_bit_multiplier between two requesters.
//  Arbitrates round-robin, registers product + requester ID, returns result on a single valid/ready channel.
//  Sits between two datapath clients (e.g. filter taps) and the one multiplier instance.
// PARAMETERS
//  N      4   operand width; product is 2N bits
//  CNT_W  8   grant-counter width (used only with MULT_ARB_STATS_EN)
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  reset      in   1    synchronous, active-high reset
//  req0_valid in   1    requester 0 has operands
//  req0_a     in   N    requester 0 operand a
//  req0_b     in   N    requester 0 operand b
//  req0_ready out  1    requester 0 transfer accepted this cycle
//  req1_valid in   1    requester 1 has operands
//  req1_a     in   N    requester 1 operand a
//  req1_b     in   N    requester 1 operand b
//  req1_ready out  1    requester 1 transfer accepted this cycle
//  res_valid  out  1    result register holds a product
//  res_id     out  1    requester that owns the result (0/1)
//  res_p      out  2N   unsigned product a*b
//  res_ready  in   1    consumer takes result this cycle
//  grant_cnt0 out  CNT_W  grants to requester 0 (MULT_ARB_STATS_EN only)
//  grant_cnt1 out  CNT_W  grants to requester 1 (MULT_ARB_STATS_EN only)
// BEHAVIOUR
//  - Reset: res_valid=0, res_id=0, res_p=0, prio=0 (req0 favoured), counters=0; reset mid-transfer drops the held result.
//  - States: EMPTY (res_valid=0), FULL (res_valid=1).
//  - can_accept = EMPTY | (FULL & res_ready).
//  - Grant only when can_accept. One valid: it wins. Both valid: requester == prio wins.
//  - reqX_ready = can_accept & grant==X: combinational, at most one high per cycle, never asserted without reqX_valid.
//  - Transfer on reqX_valid & reqX_ready. Next edge: res_p = a*b from the shared multiplier, res_id=X, FULL.
//  - prio <= ~X after each transfer; prio unchanged when no transfer occurs.
//  - Latency: 1 cycle from request accept to res_valid.
//  - Throughput: 1/cycle while res_ready stays high; drain and refill in the same cycle stay FULL.
//  - FULL & !res_ready: res_valid/res_id/res_p held stable; both readys low.
//  - FULL & res_ready & no request: -> EMPTY.
//  - Operand muxing: a single mux pair feeds the multiplier; operands from a non-granted requester never reach res_p.
//  - Product width exactly 2N, unsigned, no truncation. Max N=4: 15*15 = 225.
// CONFIGURATION
//  - MULT_ARB_STATS_EN defined: grant_cnt0/1 present; each increments by 1 on its requester's transfer, saturates at 2^CNT_W-1, cleared by reset.
//  - Not defined: counter ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package mult_arb_pkg: state encodings (ST_EMPTY, ST_FULL), requester IDs (REQ0=1'b0, REQ1=1'b1).
//  - Sub-module: one n_bit_multiplier #(N) instance (existing block), operands from the grant mux.
//  - Registers, arbiter and counters stay in this module.
// TESTING
//  1. Reset held 2 cycles, both valids high -> res_valid=0, both readys=0; first cycle after release: req0_ready=1 (prio=0).
//  2. Only req1_valid, a=3, b=5, res_ready=1 -> req1_ready=1; next cycle res_valid=1, res_id=1, res_p=15.
//  3. Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1, one result per cycle, ids match the grant order.
//  4. FULL with res_ready=0 for 3 cycles -> res_p/res_id stable, both readys 0; res_ready=1 with req0 valid (a=15, b=15) -> same-cycle refill, next res_p=225.
//  5. Reset asserted while FULL with res_ready=0 -> next cycle res_valid=0, prio=0, counters=0.
//  6. MULT_ARB_STATS_EN, CNT_W=2, 5 grants to req0 -> grant_cnt0 saturates at 3; grant_cnt1 stays 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared definitions for the two-requester multiplier arbiter:
//   result-register state encodings and requester identifiers.
package mult_arb_pkg;

  // Result register occupancy: EMPTY (no product held) / FULL (product held).
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Requester identifiers, also used as the res_id value and priority token.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage : mult_arb_pkg

// File: rtl/n_bit_multiplier.sv
// n_bit_multiplier
//   Purely combinational unsigned multiplier, full 2N-bit product.
// Ports
//   i_a  in  N    operand a
//   i_b  in  N    operand b
//   o_p  out 2N   unsigned product i_a * i_b (no truncation)
module n_bit_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  // Operands are zero-extended to the product width before multiplying so
  // the result keeps every bit.
  always_comb begin
    o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
  end

endmodule : n_bit_multiplier

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational n_bit_multiplier between two requesters.
//   Round-robin arbitration; the winning operands are multiplied and the
//   product plus owner ID are registered and offered on a single
//   valid/ready result channel. Latency 1 cycle, throughput 1/cycle.
//
// Parameters
//   N      operand width (product is 2N bits)
//   CNT_W  grant-counter width (used only with MULT_ARB_STATS_EN)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req0_valid/a/b/ready    requester 0 channel (ready = accepted this cycle)
//   req1_valid/a/b/ready    requester 1 channel
//   res_valid/id/p/ready    result channel (id = owning requester)
//   grant_cnt0/1            saturating grant counters (MULT_ARB_STATS_EN only)
//
// Configuration
//   `define MULT_ARB_STATS_EN to add the grant_cnt0/grant_cnt1 ports and logic.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           req1_ready,
  output logic           res_valid,
  output logic           res_id,
  output logic [2*N-1:0] res_p,
  input  logic           res_ready
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_t           r_state;
  logic             r_prio;
  logic             r_res_id;
  logic [2*N-1:0]   r_res_p;

  logic             w_can_accept;
  logic             w_grant_id;
  logic             w_grant_any;
  logic             w_xfer;
  logic [N-1:0]     w_op_a;
  logic [N-1:0]     w_op_b;
  logic [2*N-1:0]   w_prod;

  // Arbitration. Readys are held low while reset is asserted so no
  // requester believes it was accepted during a cycle that gets discarded.
  always_comb begin
    w_can_accept = !reset && ((r_state == ST_EMPTY) || res_ready);
    w_grant_any  = req0_valid || req1_valid;

    if (req0_valid && req1_valid) begin
      w_grant_id = r_prio;
    end else if (req1_valid) begin
      w_grant_id = REQ1;
    end else begin
      w_grant_id = REQ0;
    end

    w_xfer     = w_can_accept && w_grant_any;
    req0_ready = w_can_accept && req0_valid && (w_grant_id == REQ0);
    req1_ready = w_can_accept && req1_valid && (w_grant_id == REQ1);

    // Single operand mux pair: only the granted requester reaches the multiplier.
    w_op_a = (w_grant_id == REQ1) ? req1_a : req0_a;
    w_op_b = (w_grant_id == REQ1) ? req1_b : req0_b;
  end

  n_bit_multiplier #(
    .N (N)
  ) u_mult (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_p (w_prod)
  );

  // Result register FSM. A transfer takes precedence over draining, which
  // is what lets a drain and refill in the same cycle stay FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_EMPTY;
      r_prio   <= REQ0;
      r_res_id <= REQ0;
      r_res_p  <= '0;
    end else begin
      if (w_xfer) begin
        r_state  <= ST_FULL;
        r_res_p  <= w_prod;
        r_res_id <= w_grant_id;
        r_prio   <= ~w_grant_id;
      end else if ((r_state == ST_FULL) && res_ready) begin
        r_state  <= ST_EMPTY;
      end
    end
  end

  assign res_valid = (r_state == ST_FULL);
  assign res_id    = r_res_id;
  assign res_p     = r_res_p;

`ifdef MULT_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Saturating grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_xfer && (w_grant_id == REQ0) && (r_cnt0 != CNT_MAX)) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_xfer && (w_grant_id == REQ1) && (r_cnt1 != CNT_MAX)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  // Counter width is only meaningful when the statistics ports exist.
  localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

endmodule : mult_share_arbiter

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int unsigned N = 4;
`ifdef MULT_ARB_STATS_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 8;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           req0_valid, req1_valid;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           res_valid, res_id, res_ready;
  logic [2*N-1:0] res_p;
`ifdef MULT_ARB_STATS_EN
  logic [CW-1:0]  grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .N     (N),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_p      (res_p),
    .res_ready  (res_ready)
`ifdef MULT_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: whether a product is held, who owns it, its value,
  // which requester is favoured next, and how many grants each received.
  bit m_full;
  int m_id, m_p, m_prio, m_cnt0, m_cnt1;
  int m_cnt_max = (1 << CW) - 1;

  // Requester that should be accepted this cycle, -1 when none.
  function automatic int pick_winner();
    if (reset) return -1;
    if (m_full && !res_ready) return -1;
    if (req0_valid && req1_valid) return m_prio;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic set_in(input bit v0, input int a0, input int b0,
                        input bit v1, input int a1, input int b1, input bit rr);
    req0_valid = v0; req0_a = N'(a0); req0_b = N'(b0);
    req1_valid = v1; req1_a = N'(a1); req1_b = N'(b1);
    res_ready  = rr;
  endtask

  // One clock: decide the model outcome from pre-edge inputs, then update.
  task automatic advance();
    int w;
    int prod;
    w = pick_winner();
    prod = (w == 1) ? int'(req1_a) * int'(req1_b) : int'(req0_a) * int'(req0_b);
    @(posedge clk);
    if (reset) begin
      m_full = 0; m_id = 0; m_p = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (w >= 0) begin
      m_full = 1; m_id = w; m_p = prod; m_prio = 1 - w;
      if (w == 0 && m_cnt0 < m_cnt_max) m_cnt0++;
      if (w == 1 && m_cnt1 < m_cnt_max) m_cnt1++;
    end else if (m_full && res_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1, $urandom_range(15), $urandom_range(15), 1, $urandom_range(15), $urandom_range(15), 1);
    advance();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", res_valid); end
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
      end
      advance();
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL release_prio0: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    advance();
  endtask

  task automatic test_single_req1();
    set_in(0, 0, 0, 1, 3, 5, 1);
    #1;
    n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_err++; $display("FAIL single_req1_ready: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
    end
    advance();
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_p !== 8'd15) begin
      n_err++; $display("FAIL single_req1_result: got v=%b id=%b p=%0d want 1 1 15", res_valid, res_id, res_p);
    end
  endtask

  task automatic test_alternate();
    int exp_p;
    for (int k = 0; k < 8; k++) begin
      set_in(1, $urandom_range(15), $urandom_range(15), 1, $urandom_range(15), $urandom_range(15), 1);
      exp_p = (k % 2 == 0) ? int'(req0_a) * int'(req0_b) : int'(req1_a) * int'(req1_b);
      #1;
      n_cmp++; if (req0_ready !== 1'(k % 2 == 0) || req1_ready !== 1'(k % 2 == 1)) begin
        n_err++; $display("FAIL alt_grant[%0d]: got r0=%b r1=%b want r0=%0d", k, req0_ready, req1_ready, (k % 2 == 0));
      end
      advance();
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 1'(k % 2) || res_p !== 8'(exp_p)) begin
        n_err++; $display("FAIL alt_result[%0d]: got v=%b id=%b p=%0d want 1 %0d %0d", k, res_valid, res_id, res_p, k % 2, exp_p);
      end
    end
  endtask

  task automatic test_stall();
    int hold_id, hold_p;
    hold_id = m_id; hold_p = m_p;
    for (int c = 0; c < 3; c++) begin
      set_in(1, $urandom_range(15), $urandom_range(15), 1, $urandom_range(15), $urandom_range(15), 0);
      #1;
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_ready[%0d]: got r0=%b r1=%b want 0 0", c, req0_ready, req1_ready);
      end
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 1'(hold_id) || res_p !== 8'(hold_p)) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b id=%b p=%0d want 1 %0d %0d", c, res_valid, res_id, res_p, hold_id, hold_p);
      end
      advance();
    end
    set_in(1, 15, 15, 0, 0, 0, 1);
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL refill_ready: got %b want 1", req0_ready); end
    advance();
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 1'b0 || res_p !== 8'd225) begin
      n_err++; $display("FAIL refill_result: got v=%b id=%b p=%0d want 1 0 225", res_valid, res_id, res_p);
    end
  endtask

  task automatic test_reset_full();
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    set_in(1, $urandom_range(15), $urandom_range(15), 1, $urandom_range(15), $urandom_range(15), 0);
    #1;
    n_cmp++; if (res_valid !== 1'b0 || res_id !== 1'b0 || res_p !== 8'd0) begin
      n_err++; $display("FAIL reset_full_result: got v=%b id=%b p=%0d want 0 0 0", res_valid, res_id, res_p);
    end
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_full_prio: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
`ifdef MULT_ARB_STATS_EN
    n_cmp++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
      n_err++; $display("FAIL reset_full_cnt: got %0d %0d want 0 0", grant_cnt0, grant_cnt1);
    end
`endif
    advance();
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(1), $urandom_range(15), $urandom_range(15),
             $urandom_range(1), $urandom_range(15), $urandom_range(15),
             $urandom_range(3) != 0);
      #1;
      w = pick_winner();
      n_cmp++; if (req0_ready !== 1'(w == 0) || req1_ready !== 1'(w == 1)) begin
        n_err++; $display("FAIL rand_ready[%0d]: got r0=%b r1=%b want winner %0d", c, req0_ready, req1_ready, w);
      end
      n_cmp++; if (res_valid !== 1'(m_full)) begin
        n_err++; $display("FAIL rand_valid[%0d]: got %b want %0d", c, res_valid, m_full);
      end
      if (m_full) begin
        n_cmp++; if (res_id !== 1'(m_id) || res_p !== 8'(m_p)) begin
          n_err++; $display("FAIL rand_result[%0d]: got id=%b p=%0d want %0d %0d", c, res_id, res_p, m_id, m_p);
        end
      end
`ifdef MULT_ARB_STATS_EN
      n_cmp++; if (grant_cnt0 !== CW'(m_cnt0) || grant_cnt1 !== CW'(m_cnt1)) begin
        n_err++; $display("FAIL rand_cnt[%0d]: got %0d %0d want %0d %0d", c, grant_cnt0, grant_cnt1, m_cnt0, m_cnt1);
      end
`endif
      advance();
    end
  endtask

`ifdef MULT_ARB_STATS_EN
  task automatic test_saturate();
    set_in(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      set_in(1, $urandom_range(15), $urandom_range(15), 0, 0, 0, 1);
      advance();
    end
    n_cmp++; if (grant_cnt0 !== CW'(3) || grant_cnt1 !== CW'(0)) begin
      n_err++; $display("FAIL saturate: got cnt0=%0d cnt1=%0d want 3 0", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    m_full = 0; m_id = 0; m_p = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    test_reset();
    test_single_req1();
    test_alternate();
    test_stall();
    test_reset_full();
    test_random();
`ifdef MULT_ARB_STATS_EN
    test_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mult_share_arbiter
